// File: rtl/level_hazard_seq.sv
// Level sequencer: arms a chain of hazards in order, triggers each one on the player's X position,
// animates it open one step per tick, and drives respawn/done handshakes for the player and renderer.
module level_hazard_seq #(
    parameter int                        NUM_HAZARDS = 3,
    parameter int                        XW          = 10,
    parameter logic [NUM_HAZARDS*XW-1:0] TRIG_X      = {10'd480, 10'd320, 10'd160},
    parameter int                        TICK_DIV    = 50000,
    parameter int                        STEP_PX     = 1,
    parameter int                        OPEN_PX     = 40,
    parameter logic [XW-1:0]             SPAWN_X     = 10'd32,
    parameter logic [XW-1:0]             SPAWN_Y     = 10'd400,
    localparam int                       IW          = (NUM_HAZARDS > 1) ? $clog2(NUM_HAZARDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [XW-1:0]          player_x,
    input  logic                   death,
    output logic [2:0]             state_code,
    output logic [IW-1:0]          hazard_idx,
    output logic [XW-1:0]          hazard_offset,
    output logic [NUM_HAZARDS-1:0] open_mask,
    output logic                   spawn,
    output logic [XW-1:0]          spawn_x,
    output logic [XW-1:0]          spawn_y,
    output logic                   done,
    output logic [7:0]             death_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPAWN   = 3'd1,
        S_ARMED   = 3'd2,
        S_OPENING = 3'd3,
        S_OPENED  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [XW:0]     STEP_W    = (XW+1)'(STEP_PX);
    localparam logic [XW:0]     OPEN_W    = (XW+1)'(OPEN_PX);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_HAZARDS - 1);

    state_t                   state_reg, state_next;
    logic [IW-1:0]            idx_reg, idx_next;
    logic [XW-1:0]            offset_reg, offset_next;
    logic [NUM_HAZARDS-1:0]   mask_reg, mask_next;
    logic [TW-1:0]            tick_reg, tick_next;
    logic                     spawn_reg, spawn_next;
    logic [XW-1:0]            spawn_x_reg, spawn_x_next;
    logic [XW-1:0]            spawn_y_reg, spawn_y_next;
    logic                     done_reg, done_next;
    logic [7:0]               death_cnt_reg, death_cnt_next;

    // Threshold table padded to a power of two so any idx value selects a defined entry.
    logic [XW-1:0] trig_arr [2**IW];

    genvar gi;
    generate
        for (gi = 0; gi < 2**IW; gi++) begin : g_trig
            if (gi < NUM_HAZARDS) begin : g_use
                assign trig_arr[gi] = TRIG_X[gi*XW +: XW];
            end else begin : g_pad
                assign trig_arr[gi] = '0;
            end
        end
    endgenerate

    logic [XW:0]            offset_sum;
    logic                   offset_full;
    logic [XW-1:0]          offset_sat;
    logic [NUM_HAZARDS-1:0] idx_bit;
    logic                   death_live;

    // One extra bit keeps the step addition from wrapping before saturation.
    assign offset_sum  = {1'b0, offset_reg} + STEP_W;
    assign offset_full = (offset_sum >= OPEN_W);
    assign offset_sat  = offset_full ? OPEN_W[XW-1:0] : offset_sum[XW-1:0];
    assign idx_bit     = NUM_HAZARDS'(1) << idx_reg;
    assign death_live  = death && (state_reg == S_SPAWN || state_reg == S_ARMED ||
                                   state_reg == S_OPENING || state_reg == S_OPENED);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        offset_next    = offset_reg;
        mask_next      = mask_reg;
        tick_next      = tick_reg;
        death_cnt_next = death_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_SPAWN;
            end
            S_SPAWN: begin
                state_next = S_ARMED;
            end
            S_ARMED: begin
                if (player_x > trig_arr[idx_reg]) begin
                    state_next = S_OPENING;
                    tick_next  = '0;
                end
            end
            S_OPENING: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next   = '0;
                    offset_next = offset_sat;
                    if (offset_full) state_next = S_OPENED;
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
            S_OPENED: begin
                mask_next = mask_reg | idx_bit;
                if (idx_reg == LAST_IDX) begin
                    state_next = S_DONE;
                end else begin
                    idx_next    = idx_reg + IW'(1);
                    offset_next = '0;
                    state_next  = S_ARMED;
                end
            end
            S_DONE: begin
                if (start) state_next = S_SPAWN;
            end
            default: state_next = S_IDLE;
        endcase

        if (death_live) begin
            state_next = S_SPAWN;
            if (death_cnt_reg != 8'hFF) death_cnt_next = death_cnt_reg + 8'd1;
        end

        // Entering SPAWN wipes progress so the spawn cycle already shows a clean level.
        if (state_next == S_SPAWN) begin
            idx_next    = '0;
            offset_next = '0;
            mask_next   = '0;
            tick_next   = '0;
        end
    end

    assign spawn_next   = (state_next == S_SPAWN);
    assign spawn_x_next = spawn_next ? SPAWN_X : '0;
    assign spawn_y_next = spawn_next ? SPAWN_Y : '0;
    assign done_next    = (state_next == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            offset_reg    <= '0;
            mask_reg      <= '0;
            tick_reg      <= '0;
            spawn_reg     <= 1'b0;
            spawn_x_reg   <= '0;
            spawn_y_reg   <= '0;
            done_reg      <= 1'b0;
            death_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            offset_reg    <= offset_next;
            mask_reg      <= mask_next;
            tick_reg      <= tick_next;
            spawn_reg     <= spawn_next;
            spawn_x_reg   <= spawn_x_next;
            spawn_y_reg   <= spawn_y_next;
            done_reg      <= done_next;
            death_cnt_reg <= death_cnt_next;
        end
    end

    assign state_code    = state_reg;
    assign hazard_idx    = idx_reg;
    assign hazard_offset = offset_reg;
    assign open_mask     = mask_reg;
    assign spawn         = spawn_reg;
    assign spawn_x       = spawn_x_reg;
    assign spawn_y       = spawn_y_reg;
    assign done          = done_reg;
    assign death_count   = death_cnt_reg;

endmodule

// File: tb/tb_level_hazard_seq.sv
// Bench for level_hazard_seq: directed level walkthroughs plus a random soak, every cycle compared
// against a cycle-count based reference model of the level rules.
module tb_level_hazard_seq;

    localparam int N     = 2;
    localparam int XW    = 10;
    localparam int TD    = 4;
    localparam int STEP  = 2;
    localparam int OPEN  = 6;
    localparam int OPEN_CYC = ((OPEN + STEP - 1) / STEP) * TD;
    localparam logic [N*XW-1:0] TRIG = {10'd200, 10'd100};

    logic          clk = 1'b0;
    logic          reset, start, death;
    logic [XW-1:0] player_x;
    logic [2:0]    state_code;
    logic [0:0]    hazard_idx;
    logic [XW-1:0] hazard_offset;
    logic [N-1:0]  open_mask;
    logic          spawn, done;
    logic [XW-1:0] spawn_x, spawn_y;
    logic [7:0]    death_count;

    level_hazard_seq #(
        .NUM_HAZARDS(N), .XW(XW), .TRIG_X(TRIG), .TICK_DIV(TD),
        .STEP_PX(STEP), .OPEN_PX(OPEN), .SPAWN_X(10'd32), .SPAWN_Y(10'd400)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .player_x(player_x), .death(death),
        .state_code(state_code), .hazard_idx(hazard_idx), .hazard_offset(hazard_offset),
        .open_mask(open_mask), .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .done(done), .death_count(death_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: phase number, hazard index, cycles spent opening, mask, death tally.
    int m_state, m_idx, m_off, m_mask, m_cyc, m_deaths;
    int trig_tab [N] = '{100, 200};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_off = 0; m_mask = 0; m_cyc = 0; m_deaths = 0;
    endtask

    task automatic model_to_spawn();
        m_state = 1; m_idx = 0; m_off = 0; m_mask = 0; m_cyc = 0;
    endtask

    task automatic model_step();
        if (death && m_state >= 1 && m_state <= 4) begin
            if (m_deaths < 255) m_deaths++;
            model_to_spawn();
        end else begin
            case (m_state)
                0, 5: if (start) model_to_spawn();
                1: m_state = 2;
                2: if (int'(player_x) > trig_tab[m_idx]) begin m_state = 3; m_cyc = 0; end
                3: begin
                    m_cyc++;
                    m_off = (STEP * (m_cyc / TD) > OPEN) ? OPEN : STEP * (m_cyc / TD);
                    if (m_cyc >= OPEN_CYC) m_state = 4;
                end
                4: begin
                    m_mask = m_mask | (1 << m_idx);
                    if (m_idx == N - 1) m_state = 5;
                    else begin m_idx++; m_off = 0; m_state = 2; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        check("state_code",    state_code,    m_state);
        check("hazard_idx",    hazard_idx,    m_idx);
        check("hazard_offset", hazard_offset, m_off);
        check("open_mask",     open_mask,     m_mask);
        check("spawn",         spawn,         (m_state == 1) ? 1 : 0);
        check("spawn_x",       spawn_x,       (m_state == 1) ? 32 : 0);
        check("spawn_y",       spawn_y,       (m_state == 1) ? 400 : 0);
        check("done",          done,          (m_state == 5) ? 1 : 0);
        check("death_count",   death_count,   m_deaths);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // From ARMED with hazard 0, clear both hazards with an always-triggering X and land in DONE.
    task automatic play_level();
        player_x = 10'd1023;
        cycle();
        run(OPEN_CYC);
        cycle();
        cycle();
        run(OPEN_CYC);
        cycle();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; death = 1'b0; player_x = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b0;

        // Start pulse -> one spawn cycle, then ARMED on hazard 0.
        start = 1'b1;
        cycle();
        check("t1_spawn_x", spawn_x, 32);
        start = 1'b0;
        cycle();
        check("t1_armed", state_code, 2);

        // At or below the first threshold nothing happens; 101 triggers.
        for (int i = 0; i < 5; i++) begin
            player_x = XW'($urandom_range(0, 100));
            cycle();
        end
        player_x = 10'd100;
        cycle();
        player_x = 10'd101;
        cycle();
        check("t2_opening", state_code, 3);
        for (int i = 0; i < OPEN_CYC; i++) begin
            player_x = XW'($urandom_range(0, 1023));
            cycle();
        end
        check("t2_opened", state_code, 4);
        check("t2_full", hazard_offset, 6);
        player_x = 10'd0;
        cycle();
        check("t2_mask", open_mask, 1);
        check("t2_idx", hazard_idx, 1);

        // Second hazard at 200/201 then DONE.
        player_x = 10'd200;
        cycle();
        player_x = 10'd201;
        cycle();
        run(OPEN_CYC);
        cycle();
        check("t3_done", done, 1);
        check("t3_mask", open_mask, 3);
        run(3);

        // Replay, then die at cycle 6 of the second hazard's opening.
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        player_x = 10'd101;
        cycle();
        run(OPEN_CYC);
        cycle();
        player_x = 10'd201;
        cycle();
        run(6);
        death = 1'b1;
        cycle();
        death = 1'b0;
        check("t4_respawn", state_code, 1);
        check("t4_count", death_count, 1);

        // Held death saturates the counter.
        death = 1'b1;
        run(300);
        check("t5_sat", death_count, 255);
        death = 1'b0;
        cycle();
        play_level();
        death = 1'b1;
        run(3);
        check("t5_done_kept", done, 1);
        death = 1'b0;

        // Async reset while the first hazard is half open.
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        player_x = 10'd101;
        cycle();
        run(8);
        check("t6_mid", hazard_offset, 4);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b0;

        // Play to DONE with a fresh counter; death there and start+death must not count.
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        play_level();
        death = 1'b1;
        run(2);
        start = 1'b1;
        cycle();
        check("t6_replay_nocount", death_count, 0);
        start = 1'b0; death = 1'b0;
        cycle();
        play_level();

        // Random soak.
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            death    = ($urandom_range(0, 15) == 0);
            player_x = ($urandom_range(0, 1) == 0) ? XW'($urandom_range(95, 205))
                                                   : XW'($urandom_range(0, 1023));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
